// File: rtl/tt_pkg.sv
// Shared types and helpers for the 4-input truth-table response checker.
// Index convention: {a,b,c,d}, with a as the most significant bit.
package tt_pkg;

    localparam int TT_W  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] tt_idx(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/tt_timeout_ctr.sv
// Idle-cycle counter for the collection phase; tc flags a count of TIMEOUT-1.
// clear has priority over reload, and reload has priority over enable.
module tt_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic reload,
    input  logic enable,
    output logic tc
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || reload) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    // Leaving COLLECT drops enable, so the count can never wrap past TIMEOUT.
    assign tc = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/tt_response_checker.sv
// Captures the observed 4-input truth table from (a,b,c,d,f) samples and
// compares it against EXPECTED, reporting completion, mismatches and timeout.
module tt_response_checker
    import tt_pkg::*;
#(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int          TIMEOUT  = 64,
    parameter int          TW       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sample_valid,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        f,
    output logic [15:0] seen_mask,
    output logic [15:0] observed,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_mm_idx,
    output logic        first_mm_valid,
    output logic        unstable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    state_e           state;
    state_e           next_state;
    logic [IDX_W-1:0] idx;
    logic [TT_W-1:0]  idx_bit;
    logic             in_collect;
    logic             accept;
    logic             is_new;
    logic             completes;
    logic             tc;
    logic             time_out;

    assign idx        = tt_idx(a, b, c, d);
    assign idx_bit    = TT_W'(1) << idx;
    assign in_collect = (state == COLLECT);
    // A start pulse wins over any sample arriving on the same cycle.
    assign accept     = in_collect && sample_valid && !start;
    assign is_new     = accept && !seen_mask[idx];
    assign completes  = is_new && ((seen_mask | idx_bit) == {TT_W{1'b1}});
    assign time_out   = in_collect && !start && tc && !is_new;

    tt_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .reload (is_new),
        .enable (in_collect),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = COLLECT;
            end
            COLLECT: begin
                if (start)          next_state = COLLECT;
                else if (completes) next_state = REPORT;
                else if (time_out)  next_state = REPORT;
            end
            REPORT: begin
                if (start) next_state = COLLECT;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COLLECT);
        done = (state == REPORT);
    end

    // Result registers; held outside COLLECT until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_mask      <= '0;
            observed       <= '0;
            mismatch_count <= '0;
            first_mm_idx   <= '0;
            first_mm_valid <= 1'b0;
            unstable       <= 1'b0;
            timeout        <= 1'b0;
        end else if (start) begin
            seen_mask      <= '0;
            observed       <= '0;
            mismatch_count <= '0;
            first_mm_idx   <= '0;
            first_mm_valid <= 1'b0;
            unstable       <= 1'b0;
            timeout        <= 1'b0;
        end else if (in_collect) begin
            if (is_new) begin
                seen_mask[idx] <= 1'b1;
                observed[idx]  <= f;
                if (f != EXPECTED[idx]) begin
                    if (mismatch_count < 5'd16) begin
                        mismatch_count <= mismatch_count + 5'd1;
                    end
                    if (!first_mm_valid) begin
                        first_mm_idx   <= idx;
                        first_mm_valid <= 1'b1;
                    end
                end
            end else if (accept && (observed[idx] != f)) begin
                unstable <= 1'b1;
            end
            // Completion on the same edge excludes time_out via is_new.
            if (time_out) begin
                timeout <= 1'b1;
            end
        end
    end

    assign pass = done && (seen_mask == {TT_W{1'b1}}) &&
                  (mismatch_count == 5'd0) && !unstable;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: sweeps, mismatches, instability,
// timeout, restarts and asynchronous reset, with hand-computed results.
module tb_tt_response_checker;

    localparam logic [15:0] EXP     = 16'hA5C3;
    localparam int          TIMEOUT = 8;
    localparam int          TW      = 7;
    localparam int          RW      = 45;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        c = 1'b0;
    logic        d = 1'b0;
    logic        f = 1'b0;
    logic [15:0] seen_mask;
    logic [15:0] observed;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_mm_idx;
    logic        first_mm_valid;
    logic        unstable;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected report: {seen, observed, mm_count, first_idx, first_valid, unstable, timeout, pass}
    logic [RW-1:0] exp_q[$];

    tt_response_checker #(
        .EXPECTED (EXP),
        .TIMEOUT  (TIMEOUT),
        .TW       (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sample_valid   (sample_valid),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .f              (f),
        .seen_mask      (seen_mask),
        .observed       (observed),
        .mismatch_count (mismatch_count),
        .first_mm_idx   (first_mm_idx),
        .first_mm_valid (first_mm_valid),
        .unstable       (unstable),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sample_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int i, input logic fv);
        logic [3:0] v;
        v = i[3:0];
        start = 1'b0;
        sample_valid = 1'b1;
        {a, b, c, d} = v;
        f = fv;
        tick();
        sample_valid = 1'b0;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_report(input logic [15:0] s, input logic [15:0] o, input logic [4:0] mm,
                                 input logic [3:0] fi, input logic fv, input logic un,
                                 input logic to, input logic ps);
        exp_q.push_back({s, o, mm, fi, fv, un, to, ps});
    endtask

    task automatic check_report(input string tag);
        logic [RW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".seen"},     32'(seen_mask),      32'(e[44:29]));
            check({tag, ".observed"}, 32'(observed),       32'(e[28:13]));
            check({tag, ".mm_count"}, 32'(mismatch_count), 32'(e[12:8]));
            check({tag, ".first_idx"},32'(first_mm_idx),   32'(e[7:4]));
            check({tag, ".first_vld"},32'(first_mm_valid), 32'(e[3]));
            check({tag, ".unstable"}, 32'(unstable),       32'(e[2]));
            check({tag, ".timeout"},  32'(timeout),        32'(e[1]));
            check({tag, ".pass"},     32'(pass),           32'(e[0]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        expect_report(16'h0000, 16'h0000, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_report(tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: clean ascending sweep
        pulse_start();
        check("t1.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(i, EXP[i]);
            if (i == 14) check("t1.done_early", 32'(done), 32'd0);
        end
        check("t1.done", 32'(done), 32'd1);
        check("t1.busy_low", 32'(busy), 32'd0);
        expect_report(16'hFFFF, 16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_report("t1");
        tick();
        check("t1.done_hold", 32'(done), 32'd1);

        // 2: descending sweep, f inverted at 3 and 9
        pulse_start();
        for (int i = 15; i >= 0; i--) begin
            send(i, EXP[i] ^ ((i == 3) || (i == 9)));
        end
        check("t2.done", 32'(done), 32'd1);
        expect_report(16'hFFFF, 16'hA7CB, 5'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check_report("t2");

        // 3: index 5 sampled with 1 then 0
        pulse_start();
        send(5, 1'b1);
        send(5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i != 5) send(i, EXP[i]);
        end
        check("t3.done", 32'(done), 32'd1);
        expect_report(16'hFFFF, 16'hA5E3, 5'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check_report("t3");

        // 4: index 15 never sent -> timeout 8 cycles after index 14
        pulse_start();
        for (int i = 0; i < 15; i++) send(i, EXP[i]);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check($sformatf("t4.wait%0d", k), 32'(done), 32'd0);
        end
        tick();
        check("t4.done", 32'(done), 32'd1);
        check("t4.busy", 32'(busy), 32'd0);
        expect_report(16'h7FFF, 16'h25C3, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_report("t4");

        // 6: restart from failing REPORT, restart mid-run, then clean sweep
        pulse_start();
        check("t6.busy", 32'(busy), 32'd1);
        expect_report(16'h0000, 16'h0000, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_report("t6.clr");
        send(0, ~EXP[0]);
        send(1, EXP[1]);
        check("t6.mm_pre", 32'(mismatch_count), 32'd1);
        start = 1'b1;
        sample_valid = 1'b1;
        {a, b, c, d} = 4'd2;
        f = ~EXP[2];
        tick();
        start = 1'b0;
        sample_valid = 1'b0;
        check("t6.restart_busy", 32'(busy), 32'd1);
        expect_report(16'h0000, 16'h0000, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_report("t6.restart");
        for (int i = 0; i < 16; i++) send(i, EXP[i]);
        check("t6.done", 32'(done), 32'd1);
        expect_report(16'hFFFF, 16'hA5C3, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_report("t6");

        // 5: async reset after 6 samples
        pulse_start();
        for (int i = 0; i < 6; i++) send(i, ~EXP[i]);
        check("t5.seen_pre", 32'(seen_mask), 32'h003F);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t5.rst");
        tick();
        rst = 1'b0;
        send(7, 1'b1);
        send(8, 1'b1);
        check_all_zero("t5.ignored");
        pulse_start();
        send(3, EXP[3]);
        check("t5.after_start", 32'(seen_mask), 32'h0008);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Receiving end of the exhaustive 4-input Boolean stimulus flow: samples each applied (a,b,c,d) vector together with the circuit output F.
- Builds the observed 16-entry truth table, compares it against an expected table and reports pass/fail with mismatch diagnostics.
- Sits beside the decoder+mux Boolean circuit in synthesizable self-test and on-board checking.

Parameters:
- EXPECTED, 16'h0000, expected truth table; bit i = F for index i = {a,b,c,d} (a is MSB).
- TIMEOUT, 64, max cycles in COLLECT without a newly covered index before aborting; must be >= 2.
- TW, 7, width of timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears results and begins a collection run.
- sample_valid  in  1  a, b, c, d and f are valid this cycle.
- a, b, c, d  in  1 each  applied input vector.
- f  in  1  observed circuit output.
- seen_mask  out  16  bit i set once index i has been sampled this run.
- observed  out  16  first-captured F value per index; 0 where not seen.
- mismatch_count  out  5  number of indices whose first capture differs from EXPECTED (0..16).
- first_mm_idx  out  4  index of the earliest mismatch captured.
- first_mm_valid  out  1  first_mm_idx is meaningful.
- unstable  out  1  some index was re-sampled with a different f.
- busy  out  1  high in COLLECT.
- done  out  1  high in REPORT.
- pass  out  1  done & all 16 seen & mismatch_count==0 & !unstable.
- timeout  out  1  run ended by TIMEOUT.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0.
- All other state changes are registered on the rising edge of clk.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - Samples are ignored.
  - start -> COLLECT; seen_mask, observed, mismatch_count, first_mm_* , unstable, timeout and the timeout counter are cleared the same edge.
- COLLECT (busy=1), per sample_valid with idx={a,b,c,d}:
  - First sight of idx:
    - seen_mask[idx] and observed[idx] <= f.
    - If f != EXPECTED[idx]: mismatch_count increments; if first_mm_valid==0, first_mm_idx<=idx and first_mm_valid<=1.
    - Timeout counter reloads to 0.
  - Repeat sight with same f: no change; counter keeps incrementing.
  - Repeat sight with different f: unstable<=1 (sticky for the run); observed and mismatch_count unchanged.
  - Cycles without a new index: counter increments.
  - Transitions:
    - The sample completing seen_mask==16'hFFFF -> REPORT on the next edge. Outputs reflect that sample the cycle done rises, so latency from the last new sample to done is 1 cycle.
    - Counter reaching TIMEOUT-1 without a new index -> REPORT with timeout=1.
    - Completion and timeout on the same edge: completion wins, timeout=0.
  - start in COLLECT restarts the run: clears as in IDLE and remains in COLLECT; the sample on that cycle is ignored.
- REPORT (done=1):
  - All result outputs are held; pass is combinational from the held results.
  - start -> COLLECT with clear; otherwise stays.
- mismatch_count saturates at 16; it cannot exceed 16 by construction.
- Async reset mid-run discards all results.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, COLLECT, REPORT}.
  - TT_W=16, IDX_W=4.
  - Function tt_idx(a,b,c,d) returning {a,b,c,d}.
- Natural sub-module tt_timeout_ctr: TW-bit counter with clear/reload/enable and a terminal-count output at TIMEOUT-1.

Test Plan:
- EXPECTED=16'hA5C3; start, then indices 0..15 in order on consecutive cycles with f=EXPECTED[i] -> done rises 1 cycle after index 15; pass=1, mismatch_count=0, seen_mask=16'hFFFF, observed=16'hA5C3.
- Same EXPECTED; f inverted at indices 3 and 9, order 15..0 -> mismatch_count=2, first_mm_idx=9, first_mm_valid=1, pass=0.
- Index 5 sampled twice, f=1 then f=0 (EXPECTED[5]=0), others correct -> observed[5]=1, mismatch_count=1, unstable=1, pass=0.
- TIMEOUT=8; only indices 0..14 sent, then idle -> REPORT exactly 8 cycles after index 14; timeout=1, seen_mask=16'h7FFF, pass=0.
- Assert rst during COLLECT after 6 samples -> all outputs 0 immediately, state IDLE; samples ignored until start.
- start pulse in REPORT after a failing run, then a clean exhaustive sweep -> results cleared on restart; final pass=1.
